glyph_pixel_pipe: RTL and testbench

Pixel-generation stage directly downstream of the VGA timing/glyph-select controller. Per pixel it takes the controller's counters, glyph code, glyph box origin and text colour, looks up an 8x8 bitmap in an internal glyph ROM, scales it by 2^SCALE_SHIFT, and drives registered 8-bit R/G/B plus sync/blank aligned to the pixel data. It is a pixel-enable-gated 3-stage pipeline, so the timing and lookup logic can close at the system clock.

---
 rtl/glyph_pixel_pipe.sv | 156 +++++++++++++++
 tb/tb_glyph_pixel_pipe.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_pixel_pipe.sv
// glyph_pixel_pipe: three-stage pixel generator that renders scaled 8x8 glyphs
// from a built-in ROM, keeping RGB, syncs and blank mutually aligned.
module glyph_pixel_pipe #(
  parameter int unsigned SCALE_SHIFT = 3,
  parameter logic [23:0] BG_COLOR    = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        bright,
  input  logic        main,
  input  logic [5:0]  gbval,
  input  logic [9:0]  x_start,
  input  logic [9:0]  y_start,
  input  logic [23:0] rgb_color,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_o
);

  localparam int unsigned CoordW = 10;
  localparam int unsigned ColorW = 24;

  // Glyph bitmap row lookup; codes 0x12-0x1F are all-zero, bit 7 is the leftmost column.
  function automatic logic [7:0] f_glyph_row(input logic [4:0] code, input logic [2:0] row);
    logic [63:0] g;
    g = 64'h0;
    case (code)
      5'h00: g = 64'h3C66666666663C00;
      5'h01: g = 64'h1838181818187E00;
      5'h02: g = 64'h3C66060C30607E00;
      5'h03: g = 64'h3C66061C06663C00;
      5'h04: g = 64'h0C1C3C6C7E0C0C00;
      5'h05: g = 64'h7E607C0606663C00;
      5'h06: g = 64'h3C607C6666663C00;
      5'h07: g = 64'h7E060C1830303000;
      5'h08: g = 64'h3C66663C66663C00;
      5'h09: g = 64'h3C66663E060C3800;
      5'h0A: g = 64'h183C66667E666600;
      5'h0B: g = 64'h7C66667C66667C00;
      5'h0C: g = 64'h3C66606060663C00;
      5'h0D: g = 64'h786C6666666C7800;
      5'h0E: g = 64'h7E60607C60607E00;
      5'h0F: g = 64'h7E60607C60606000;
      5'h11: g = 64'h8142241818244281;
      default: g = 64'h0;
    endcase
    f_glyph_row = g[{3'(3'd7 - row), 3'b000} +: 8];
  endfunction

  // Stage 1 combinational: box-relative offset, scaled cell index and box guard.
  logic [CoordW-1:0] w_dx, w_dy, w_col, w_row;
  logic              w_in_box;
  logic              w_unused;

  assign w_dx     = hcount - x_start;
  assign w_dy     = vcount - y_start;
  assign w_col    = w_dx >> SCALE_SHIFT;
  assign w_row    = w_dy >> SCALE_SHIFT;
  assign w_in_box = main & (w_col < CoordW'(8)) & (w_row < CoordW'(8));
  assign w_unused = gbval[5];

  logic [2:0]        r1_row, r1_col;
  logic [4:0]        r1_code;
  logic [ColorW-1:0] r1_rgb;
  logic              r1_bright, r1_hs, r1_vs, r1_in_box;

  // Stage 1 registers: capture cell coordinates, code, colour and timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_row    <= '0;
      r1_col    <= '0;
      r1_code   <= '0;
      r1_rgb    <= '0;
      r1_bright <= 1'b0;
      r1_hs     <= 1'b1;
      r1_vs     <= 1'b1;
      r1_in_box <= 1'b0;
    end else if (pix_en) begin
      r1_row    <= w_row[2:0];
      r1_col    <= w_col[2:0];
      r1_code   <= gbval[4:0];
      r1_rgb    <= rgb_color;
      r1_bright <= bright;
      r1_hs     <= hsync_in;
      r1_vs     <= vsync_in;
      r1_in_box <= w_in_box;
    end
  end

  logic [7:0]        r2_rom_q;
  logic [2:0]        r2_col;
  logic [ColorW-1:0] r2_rgb;
  logic              r2_bright, r2_hs, r2_vs, r2_in_box;

  // Stage 2: synchronous ROM read with side-band signals carried alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      r2_rom_q  <= '0;
      r2_col    <= '0;
      r2_rgb    <= '0;
      r2_bright <= 1'b0;
      r2_hs     <= 1'b1;
      r2_vs     <= 1'b1;
      r2_in_box <= 1'b0;
    end else if (pix_en) begin
      r2_rom_q  <= f_glyph_row(r1_code, r1_row);
      r2_col    <= r1_col;
      r2_rgb    <= r1_rgb;
      r2_bright <= r1_bright;
      r2_hs     <= r1_hs;
      r2_vs     <= r1_vs;
      r2_in_box <= r1_in_box;
    end
  end

  // Stage 3 combinational: pick the glyph bit and resolve the pixel colour.
  logic              w_bit;
  logic [ColorW-1:0] w_pix;

  always_comb begin
    w_bit = r2_rom_q[3'(3'd7 - r2_col)];
    w_pix = BG_COLOR;
    if (!r2_bright)
      w_pix = '0;
    else if (r2_in_box && w_bit)
      w_pix = r2_rgb;
  end

  // Stage 3 registers: drive colour, syncs and blank on the same strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_o <= 1'b0;
    end else if (pix_en) begin
      vga_r       <= w_pix[23:16];
      vga_g       <= w_pix[15:8];
      vga_b       <= w_pix[7:0];
      vga_hs      <= r2_hs;
      vga_vs      <= r2_vs;
      vga_blank_o <= r2_bright;
    end
  end

endmodule

// File: tb/tb_glyph_pixel_pipe.sv
// Bench for glyph_pixel_pipe: directed scenarios plus randomized traffic
// checked against a per-pixel reference model and a latency queue.
module tb_glyph_pixel_pipe;

  localparam logic [23:0] BG = 24'hFFFFFF;
  localparam int unsigned SHIFT = 3;
  localparam logic [26:0] RST_OUT = {24'h000000, 1'b1, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst, pix_en;
  logic [9:0]  hcount, vcount, x_start, y_start;
  logic        hsync_in, vsync_in, bright, main;
  logic [5:0]  gbval;
  logic [23:0] rgb_color;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] font [32];
  logic [26:0] exp_q [$];
  logic [26:0] exp_now;
  logic [26:0] got;

  always #5 clk = ~clk;

  glyph_pixel_pipe #(.SCALE_SHIFT(SHIFT), .BG_COLOR(BG)) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .bright(bright), .main(main),
    .gbval(gbval), .x_start(x_start), .y_start(y_start), .rgb_color(rgb_color),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_o(vga_blank_o)
  );

  assign got = {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_o};

  // Reference pixel: what the current inputs should produce once they reach the output.
  function automatic logic [26:0] model();
    int dx, dy, col, row;
    bit in_box, pix_bit;
    logic [23:0] rgb;
    logic [63:0] g;
    dx = ((int'(hcount) - int'(x_start)) % 1024 + 1024) % 1024;
    dy = ((int'(vcount) - int'(y_start)) % 1024 + 1024) % 1024;
    col = dx / (1 << SHIFT);
    row = dy / (1 << SHIFT);
    in_box = main && (col < 8) && (row < 8);
    pix_bit = 1'b0;
    if (in_box) begin
      g = font[gbval[4:0]];
      pix_bit = g[63 - row * 8 - col];
    end
    if (!bright) rgb = 24'h0;
    else if (in_box && pix_bit) rgb = rgb_color;
    else rgb = BG;
    return {rgb, hsync_in, vsync_in, bright};
  endfunction

  // One clk with the given strobe; advances the expected-output queue like the real pipe.
  task automatic tick(input logic en);
    pix_en = en;
    @(posedge clk);
    if (rst) begin
      exp_q = {RST_OUT, RST_OUT};
      exp_now = RST_OUT;
    end else if (en) begin
      exp_q.push_back(model());
      exp_now = exp_q.pop_front();
    end
    #1;
  endtask

  task automatic rand_inputs();
    hcount    = 10'($urandom_range(0, 799));
    vcount    = 10'($urandom_range(0, 524));
    x_start   = 10'(hcount - 10'($urandom_range(0, 80)));
    y_start   = 10'(vcount - 10'($urandom_range(0, 80)));
    main      = ($urandom_range(0, 7) != 0);
    bright    = ($urandom_range(0, 7) != 0);
    gbval     = 6'($urandom);
    rgb_color = 24'($urandom);
    hsync_in  = 1'($urandom);
    vsync_in  = 1'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_inputs();
      tick(1'(i));
      n_tests++;
      if (got !== 27'({24'h0, 1'b1, 1'b1, 1'b0})) begin
        n_fail++;
        $display("FAIL reset_state got=%h exp=%h", got, RST_OUT);
      end
    end
    rst = 1'b0;
    bright = 1'b1;
    main = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      n_tests++;
      if (got !== exp_now || (i < 2 && vga_blank_o !== 1'b0) || (i == 2 && vga_blank_o !== 1'b1)) begin
        n_fail++;
        $display("FAIL reset_flush strobe=%0d got=%h exp=%h", i, got, exp_now);
      end
    end
  endtask

  task automatic test_latency();
    int low_cnt, low_at;
    low_cnt = 0;
    low_at = -1;
    bright = 1'b1; main = 1'b0; vsync_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      hcount = 10'(14 + i);
      hsync_in = (hcount != 10'd16);
      tick(1'b1);
      if (vga_hs === 1'b0) begin low_cnt++; low_at = i; end
      n_tests++;
      if (got !== exp_now) begin
        n_fail++;
        $display("FAIL latency_pixel i=%0d got=%h exp=%h", i, got, exp_now);
      end
    end
    n_tests++;
    if (low_cnt != 1 || low_at != 4) begin
      n_fail++;
      $display("FAIL latency_hs low_count=%0d low_at=%0d exp_count=1 exp_at=4", low_cnt, low_at);
    end
  endtask

  task automatic test_glyph_hit();
    bright = 1'b1; main = 1'b1; gbval = 6'h11; hsync_in = 1'b1; vsync_in = 1'b1;
    x_start = 10'd336; y_start = 10'd175; rgb_color = 24'h343a40;
    hcount = 10'd336; vcount = 10'd175;
    for (int i = 0; i < 3; i++) tick(1'b1);
    n_tests++;
    if (got[26:3] !== 24'h343a40 || got !== exp_now) begin
      n_fail++;
      $display("FAIL glyph_hit got=%h exp_rgb=343a40", got[26:3]);
    end
    hcount = 10'd344;
    for (int i = 0; i < 3; i++) tick(1'b1);
    n_tests++;
    if (got[26:3] !== BG || got !== exp_now) begin
      n_fail++;
      $display("FAIL glyph_bg got=%h exp_rgb=%h", got[26:3], BG);
    end
  endtask

  task automatic test_scaling();
    bright = 1'b1; main = 1'b1; gbval = 6'h00; rgb_color = 24'h12ab34;
    x_start = 10'd272; y_start = 10'd175;
    for (int i = 0; i < 8; i++) begin
      vcount = 10'(175 + 24 + i);
      hcount = 10'd280;
      for (int k = 0; k < 3; k++) tick(1'b1);
      n_tests++;
      if (got[26:3] !== 24'h12ab34 || got !== exp_now) begin
        n_fail++;
        $display("FAIL scale_fg line=%0d got=%h exp=12ab34", i, got[26:3]);
      end
    end
    hcount = 10'd272;
    for (int k = 0; k < 3; k++) tick(1'b1);
    n_tests++;
    if (got[26:3] !== BG || got !== exp_now) begin
      n_fail++;
      $display("FAIL scale_bg got=%h exp=%h", got[26:3], BG);
    end
  endtask

  task automatic test_out_of_box();
    bright = 1'b1; main = 1'b1; gbval = 6'h11; rgb_color = 24'h00ff00;
    x_start = 10'd100; y_start = 10'd100; hcount = 10'd100; vcount = 10'd170;
    for (int k = 0; k < 3; k++) tick(1'b1);
    n_tests++;
    if (got[26:3] !== BG || got !== exp_now) begin
      n_fail++;
      $display("FAIL out_of_box_row got=%h exp=%h", got[26:3], BG);
    end
    vcount = 10'd100; hcount = 10'd164;
    for (int k = 0; k < 3; k++) tick(1'b1);
    n_tests++;
    if (got[26:3] !== BG || got !== exp_now) begin
      n_fail++;
      $display("FAIL out_of_box_col got=%h exp=%h", got[26:3], BG);
    end
  endtask

  task automatic test_bright_off();
    bright = 1'b0; main = 1'b1; gbval = 6'h11; rgb_color = 24'habcdef;
    x_start = 10'd336; y_start = 10'd175; hcount = 10'd336; vcount = 10'd175;
    for (int k = 0; k < 3; k++) tick(1'b1);
    n_tests++;
    if (got[26:3] !== 24'h0 || vga_blank_o !== 1'b0 || got !== exp_now) begin
      n_fail++;
      $display("FAIL bright_off got=%h exp=%h", got, exp_now);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin rand_inputs(); tick(1'b1); end
    for (int i = 0; i < 5; i++) begin
      rand_inputs();
      tick(1'b0);
      n_tests++;
      if (got !== exp_now) begin
        n_fail++;
        $display("FAIL stall_hold clk=%0d got=%h exp=%h", i, got, exp_now);
      end
    end
    for (int i = 0; i < 4; i++) begin
      rand_inputs();
      tick(1'b1);
      n_tests++;
      if (got !== exp_now) begin
        n_fail++;
        $display("FAIL stall_resume i=%0d got=%h exp=%h", i, got, exp_now);
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) begin rand_inputs(); tick(1'b1); end
    rst = 1'b1;
    tick(1'b0);
    rst = 1'b0;
    n_tests++;
    if (got !== RST_OUT) begin
      n_fail++;
      $display("FAIL mid_reset got=%h exp=%h", got, RST_OUT);
    end
    for (int i = 0; i < 4; i++) begin
      rand_inputs();
      bright = 1'b1;
      tick(1'b1);
      n_tests++;
      if (got !== exp_now) begin
        n_fail++;
        $display("FAIL mid_reset_flush i=%0d got=%h exp=%h", i, got, exp_now);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      tick(1'($urandom_range(0, 3) != 0));
      n_tests++;
      if (got !== exp_now) begin
        n_fail++;
        $display("FAIL back_to_back i=%0d got=%h exp=%h", i, got, exp_now);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) font[i] = 64'h0;
    font[5'h00] = 64'h3C66666666663C00; font[5'h01] = 64'h1838181818187E00;
    font[5'h02] = 64'h3C66060C30607E00; font[5'h03] = 64'h3C66061C06663C00;
    font[5'h04] = 64'h0C1C3C6C7E0C0C00; font[5'h05] = 64'h7E607C0606663C00;
    font[5'h06] = 64'h3C607C6666663C00; font[5'h07] = 64'h7E060C1830303000;
    font[5'h08] = 64'h3C66663C66663C00; font[5'h09] = 64'h3C66663E060C3800;
    font[5'h0A] = 64'h183C66667E666600; font[5'h0B] = 64'h7C66667C66667C00;
    font[5'h0C] = 64'h3C66606060663C00; font[5'h0D] = 64'h786C6666666C7800;
    font[5'h0E] = 64'h7E60607C60607E00; font[5'h0F] = 64'h7E60607C60606000;
    font[5'h11] = 64'h8142241818244281;
    rst = 1'b0; pix_en = 1'b0;
    hcount = '0; vcount = '0; x_start = '0; y_start = '0;
    hsync_in = 1'b1; vsync_in = 1'b1; bright = 1'b0; main = 1'b0;
    gbval = '0; rgb_color = '0;
    exp_now = RST_OUT;
    test_reset();
    test_latency();
    test_glyph_hit();
    test_scaling();
    test_out_of_box();
    test_bright_off();
    test_stall();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
